syn_fgyrus_pcm_fetch: RTL
=========================

Name: syn_fgyrus_pcm_fetch

Overview:
- Fgyrus-side consumer of the dual PCM sample buffers.
- On each buffer-ready pulse it reads all 2^P_PCM_RAM_ADDR_W sample pairs (left + right) through the two buffer read ports.
- It absorbs the fixed RAM read latency and streams the pairs to the FFT butterfly datapath over a valid/ready handshake, in FFT input order.
- Sits between the audio-cache port-B memory interfaces and the Fgyrus FFT engine, entirely in the Fgyrus clock domain.

Parameters:
- P_PCM_RAM_DATA_W, 32, width of one channel sample.
- P_PCM_RAM_ADDR_W, 7, buffer address width; frame length N = 2^P_PCM_RAM_ADDR_W = 128.
- P_RAM_RD_DELAY, 2, cycles from rden to rd_valid/rdata.
- P_FIFO_DEPTH, 4, skid FIFO entries (power of 2, >= P_RAM_RD_DELAY+2).
- P_OVRFLW_CNT_W, 8, width of the dropped-pulse counter.

Ports:
- clk_ir  in  1  Fgyrus clock
- rst_sync_l  in  1  synchronous active-low reset
- pcm_data_rdy_oh  in  1  one-cycle pulse: a full buffer is available (already in clk_ir domain)
- lmem_addr  out  P_PCM_RAM_ADDR_W  left-buffer read address
- lmem_rden  out  1  left read enable
- lmem_wren  out  1  left write enable, constant 0
- lmem_wdata  out  P_PCM_RAM_DATA_W  constant 0
- lmem_rdata  in  P_PCM_RAM_DATA_W  left read data
- lmem_rd_valid  in  1  left read data valid
- rmem_addr / rmem_rden / rmem_wren / rmem_wdata / rmem_rdata / rmem_rd_valid  same as left, right channel
- smpl_valid  out  1  output sample pair valid
- smpl_ready  in  1  downstream accept
- smpl_lchnnl  out  P_PCM_RAM_DATA_W  left sample
- smpl_rchnnl  out  P_PCM_RAM_DATA_W  right sample
- smpl_idx  out  P_PCM_RAM_ADDR_W  buffer address the pair came from
- smpl_sof  out  1  first beat of frame
- smpl_eof  out  1  last beat of frame
- busy  out  1  state != IDLE
- ovrflw_cnt  out  P_OVRFLW_CNT_W  ready pulses dropped while busy, saturating

Behaviour:
- Clock and reset: single clock clk_ir. Reset is synchronous, active-low (rst_sync_l sampled on posedge clk_ir).
- Reset values:
  - all outputs 0; FSM = IDLE
  - issue counter, beat counter, outstanding counter and FIFO pointers = 0
- FSM IDLE -> FETCH: pcm_data_rdy_oh=1 in IDLE. Issue counter cleared.
- FSM FETCH -> DRAIN: the read for issue count N-1 is issued.
- FSM DRAIN -> IDLE: outstanding==0, FIFO empty and final beat accepted (smpl_valid & smpl_ready & smpl_eof).
- Issue rule:
  - in FETCH, rden (l and r driven identically, same address) asserts when outstanding + fifo_count < P_FIFO_DEPTH.
  - Issue counter increments per issued read; addr = f(issue counter), where f is the address-order function (see Optional Feature).
- Outstanding counter: +1 on issue, -1 on lmem_rd_valid; both in the same cycle -> unchanged.
- Return path: FIFO push on lmem_rd_valid, entry {lmem_rdata, rmem_rdata, idx}. Idx is tracked through a P_RAM_RD_DELAY shift pipeline aligned with rden.
- rmem_rd_valid mismatch: if rmem_rd_valid != lmem_rd_valid in any cycle, set sticky internal err bit, cleared only by reset. Observable in simulation via assertion.
- Output side:
  - FIFO is show-ahead; smpl_valid = !fifo_empty.
  - Pop on smpl_valid & smpl_ready.
  - Data must hold stable while valid & !ready.
- sof = beat counter==0; eof = beat counter==N-1. Beat counter increments per accepted beat, wraps to 0 after N-1.
- Latency: pulse at cycle 0 -> first rden at cycle 1 -> first smpl_valid at cycle 1+P_RAM_RD_DELAY+1 = 4.
- Throughput: 1 pair/cycle with smpl_ready held high.
- Overflow: pcm_data_rdy_oh while not IDLE (including the DRAIN->IDLE cycle) is dropped. ovrflw_cnt increments, saturating at all-ones. The current frame is unaffected.
- Reset mid-frame: everything returns to reset values next cycle. In-flight RAM returns arriving after reset are ignored (outstanding reset to 0; pushes only accepted when state != IDLE).
- FIFO full with rd_valid: cannot occur by the credit rule; assertion required.

Optional Feature:
- Macro: SYN_FGYRUS_PCM_BIT_REV_EN.
- Defined: f(i) = bit-reverse of i over P_PCM_RAM_ADDR_W bits. Output order is 0,64,32,96,16,... (decimation-in-time FFT input order).
- Undefined: f(i) = i, linear order 0,1,2,...,127.
- smpl_idx always reports the actual buffer address.

Decomposition:
- syn_audio_pkg additions:
  - typedef enum pcm_fetch_fsm_t {IDLE, FETCH, DRAIN}
  - typedef struct packed pcm_smpl_pair_t {lchnnl, rchnnl}
  - function bit_rev
- Sub-module: syn_fgyrus_pcm_fifo, a synchronous show-ahead FIFO (parameters width and depth; outputs count, full, empty).

Test Plan:
- Single pulse, smpl_ready=1, macro undefined -> first smpl_valid 4 cycles after pulse; 128 consecutive beats idx 0..127; sof on idx 0, eof on idx 127; data matches preloaded RAM model; busy drops after last beat.
- Macro defined, same stimulus -> idx sequence 0,64,32,96,16,80,... and data matches RAM[idx].
- smpl_ready=0 after pulse for 20 cycles -> exactly 4 rden issued, then none; releasing ready yields all 128 beats with no loss or duplication.
- Random smpl_ready (50%) -> all 128 pairs in order; outputs stable whenever valid & !ready; outstanding never exceeds 4 - fifo_count.
- Second pulse at beat 50 -> ovrflw_cnt 0->1, frame completes normally; 300 extra pulses while busy -> ovrflw_cnt saturates at 255.
- rst_sync_l low for 1 cycle at beat 60 -> all outputs 0 next cycle, no late pushes; next pulse restarts cleanly at idx 0 with sof.

Source files
------------

// File: rtl/syn_fgyrus_pcm_fetch_pkg.sv
// syn_fgyrus_pcm_fetch_pkg: shared types for the Fgyrus PCM fetch path.
// Fetch FSM states, L/R sample-pair struct, address bit-reversal helper.
package syn_fgyrus_pcm_fetch_pkg;

  localparam int PCM_DATA_W    = 32;
  localparam int PCM_ADDR_W    = 7;
  localparam int BIT_REV_MAX_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } pcm_fetch_fsm_t;

  typedef struct packed {
    logic [PCM_DATA_W-1:0] lchnnl;
    logic [PCM_DATA_W-1:0] rchnnl;
  } pcm_smpl_pair_t;

  // Reverses the low w bits of v; bits above w come back as zero.
  function automatic logic [BIT_REV_MAX_W-1:0] bit_rev(
    input logic [BIT_REV_MAX_W-1:0] v,
    input int                       w
  );
    logic [BIT_REV_MAX_W-1:0] r;
    for (int i = 0; i < BIT_REV_MAX_W; i++)
      r[i] = v[BIT_REV_MAX_W-1-i];
    return r >> (BIT_REV_MAX_W - w);
  endfunction

endpackage

// File: rtl/syn_fgyrus_pcm_fetch_if.sv
// syn_fgyrus_pcm_fetch_if: PCM sample-pair stream into the FFT datapath.
// valid/ready, lchnnl, rchnnl, idx, sof, eof; master = fetch, slave = FFT.
interface syn_fgyrus_pcm_fetch_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] lchnnl;
  logic [DATA_W-1:0] rchnnl;
  logic [ADDR_W-1:0] idx;
  logic              sof;
  logic              eof;

  modport master (
    output valid, lchnnl, rchnnl, idx, sof, eof,
    input  ready
  );

  modport slave (
    input  valid, lchnnl, rchnnl, idx, sof, eof,
    output ready
  );
endinterface

// File: rtl/syn_fgyrus_pcm_fifo.sv
// syn_fgyrus_pcm_fifo: synchronous show-ahead FIFO (sync active-low reset).
// push/wdata in, pop/rdata out (rdata = head), count, full, empty.
module syn_fgyrus_pcm_fifo #(
  parameter  int WIDTH = 71,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    wr_ptr;
  logic [CW-1:0]    rd_ptr;

  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  a_no_push_full: assert property (
    @(posedge clk) disable iff (!rst_n) !(push && full)
  );

endmodule

// File: rtl/syn_fgyrus_pcm_fetch.sv
// syn_fgyrus_pcm_fetch: reads a full L/R PCM frame per buffer-ready pulse,
// absorbs RAM read latency in a credit-limited skid FIFO, streams pairs.
// Ports: clk_ir, rst_sync_l, pcm_data_rdy_oh, lmem_*/rmem_* RAM port B,
// smpl (stream master), busy, ovrflw_cnt (saturating dropped pulses).
// Macro SYN_FGYRUS_PCM_BIT_REV_EN: fetch in bit-reversed address order.
module syn_fgyrus_pcm_fetch
  import syn_fgyrus_pcm_fetch_pkg::*;
#(
  parameter int P_PCM_RAM_DATA_W = 32,
  parameter int P_PCM_RAM_ADDR_W = 7,
  parameter int P_RAM_RD_DELAY   = 2,
  parameter int P_FIFO_DEPTH     = 4,
  parameter int P_OVRFLW_CNT_W   = 8
) (
  input  logic                        clk_ir,
  input  logic                        rst_sync_l,
  input  logic                        pcm_data_rdy_oh,
  output logic [P_PCM_RAM_ADDR_W-1:0] lmem_addr,
  output logic                        lmem_rden,
  output logic                        lmem_wren,
  output logic [P_PCM_RAM_DATA_W-1:0] lmem_wdata,
  input  logic [P_PCM_RAM_DATA_W-1:0] lmem_rdata,
  input  logic                        lmem_rd_valid,
  output logic [P_PCM_RAM_ADDR_W-1:0] rmem_addr,
  output logic                        rmem_rden,
  output logic                        rmem_wren,
  output logic [P_PCM_RAM_DATA_W-1:0] rmem_wdata,
  input  logic [P_PCM_RAM_DATA_W-1:0] rmem_rdata,
  input  logic                        rmem_rd_valid,
  syn_fgyrus_pcm_fetch_if.master      smpl,
  output logic                        busy,
  output logic [P_OVRFLW_CNT_W-1:0]   ovrflw_cnt
);

  localparam int D  = P_PCM_RAM_DATA_W;
  localparam int A  = P_PCM_RAM_ADDR_W;
  localparam int CW = $clog2(P_FIFO_DEPTH) + 1;
  localparam int FW = 2 * D + A;
  localparam logic [A-1:0] LAST_IDX = '1;
  localparam logic [CW:0]  DEPTH_C  = (CW + 1)'(P_FIFO_DEPTH);

  pcm_fetch_fsm_t state;
  logic [A-1:0]   issue_cnt;
  logic [A-1:0]   beat_cnt;
  logic [CW-1:0]  outst;
  logic [A-1:0]   idx_pipe [P_RAM_RD_DELAY];
  logic           err;

  logic [A-1:0]   rd_addr;
  logic           rden;
  logic           ret;
  logic           fire;
  logic           eof;

  logic [FW-1:0]  fifo_wdata;
  logic [FW-1:0]  fifo_rdata;
  logic [CW-1:0]  fifo_count;
  logic           fifo_full;
  logic           fifo_empty;

`ifdef SYN_FGYRUS_PCM_BIT_REV_EN
  assign rd_addr = A'(bit_rev(BIT_REV_MAX_W'(issue_cnt), A));
`else
  assign rd_addr = issue_cnt;
`endif

  // Credit: reads in flight plus buffered pairs never exceed the FIFO.
  assign rden = (state == FETCH) &&
                (({1'b0, outst} + {1'b0, fifo_count}) < DEPTH_C);

  // Returns are only legal against an outstanding read; stale returns
  // from before a reset find outst == 0 and are dropped.
  assign ret  = lmem_rd_valid && (state != IDLE) && (outst != '0);
  assign fire = !fifo_empty && smpl.ready;
  assign eof  = !fifo_empty && (beat_cnt == LAST_IDX);

  assign lmem_addr  = rd_addr;
  assign rmem_addr  = rd_addr;
  assign lmem_rden  = rden;
  assign rmem_rden  = rden;
  assign lmem_wren  = 1'b0;
  assign rmem_wren  = 1'b0;
  assign lmem_wdata = '0;
  assign rmem_wdata = '0;

  assign fifo_wdata = {lmem_rdata, rmem_rdata, idx_pipe[P_RAM_RD_DELAY-1]};

  syn_fgyrus_pcm_fifo #(
    .WIDTH (FW),
    .DEPTH (P_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_ir),
    .rst_n (rst_sync_l),
    .push  (ret),
    .wdata (fifo_wdata),
    .pop   (fire),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign smpl.valid  = !fifo_empty;
  assign smpl.lchnnl = fifo_empty ? '0 : fifo_rdata[FW-1 -: D];
  assign smpl.rchnnl = fifo_empty ? '0 : fifo_rdata[FW-D-1 -: D];
  assign smpl.idx    = fifo_empty ? '0 : fifo_rdata[A-1:0];
  assign smpl.sof    = !fifo_empty && (beat_cnt == '0);
  assign smpl.eof    = eof;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk_ir) begin
    if (!rst_sync_l) begin
      state      <= IDLE;
      issue_cnt  <= '0;
      beat_cnt   <= '0;
      outst      <= '0;
      ovrflw_cnt <= '0;
      err        <= 1'b0;
      for (int i = 0; i < P_RAM_RD_DELAY; i++)
        idx_pipe[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pcm_data_rdy_oh) begin
            state     <= FETCH;
            issue_cnt <= '0;
          end
        end
        FETCH: begin
          if (rden) begin
            issue_cnt <= issue_cnt + 1'b1;
            if (issue_cnt == LAST_IDX)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fire && eof && (outst == '0) && (fifo_count == CW'(1)))
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (pcm_data_rdy_oh && (state != IDLE) && (ovrflw_cnt != '1))
        ovrflw_cnt <= ovrflw_cnt + 1'b1;

      unique case ({rden, ret})
        2'b10:   outst <= outst + 1'b1;
        2'b01:   outst <= outst - 1'b1;
        default: ;
      endcase

      idx_pipe[0] <= rd_addr;
      for (int i = 1; i < P_RAM_RD_DELAY; i++)
        idx_pipe[i] <= idx_pipe[i-1];

      if (fire)
        beat_cnt <= beat_cnt + 1'b1;

      if (lmem_rd_valid != rmem_rd_valid)
        err <= 1'b1;
    end
  end

  a_rd_valid_match: assert property (
    @(posedge clk_ir) disable iff (!rst_sync_l) !err
  );

  a_no_push_full: assert property (
    @(posedge clk_ir) disable iff (!rst_sync_l) !(ret && fifo_full)
  );

endmodule
